// File: rtl/sd_audvid_pkg.sv
// Shared definitions for the AudVid SD sector arbiter: FSM states, sector size,
// timeout default and requester indices, plus the round-robin pick helper.
package sd_audvid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } arbState_t;

    localparam int SECTOR_BYTES           = 512;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    localparam logic REQ_VIDEO = 1'b0;
    localparam logic REQ_AUDIO = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic pickRequester(input logic videoReq,
                                           input logic audioReq,
                                           input logic lastServed);
        logic winner;
        if (videoReq && audioReq) begin
            winner = (lastServed == REQ_VIDEO) ? REQ_AUDIO : REQ_VIDEO;
        end else if (audioReq) begin
            winner = REQ_AUDIO;
        end else begin
            winner = REQ_VIDEO;
        end
        return winner;
    endfunction

endpackage

// File: rtl/sd_sector_arbiter.sv
// Arbitrates SD sector reads between the video and audio fetchers and routes the
// 512-byte data phase to the owner. Optional WAIT timeout: SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter
    import sd_audvid_pkg::*;
#(
    parameter int ADDR_W = 16
`ifdef SD_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
    input  logic              DataClock,
    input  logic              Reset,
    input  logic              VideoReq,
    input  logic [ADDR_W-1:0] VideoAddr,
    input  logic              AudioReq,
    input  logic [ADDR_W-1:0] AudioAddr,
    output logic              VideoGrant,
    output logic              AudioGrant,
    output logic [7:0]        OutByte,
    output logic              VideoByteValid,
    output logic              AudioByteValid,
    output logic              VideoDone,
    output logic              AudioDone,
    output logic              XferErr,
    output logic [ADDR_W-1:0] SectorAddress,
    output logic              SectorStart,
    input  logic              EnableDataRead,
    input  logic [7:0]        InputData
);

    arbState_t   state;
    arbState_t   stateNext;
    logic [9:0]  byteCount;
    logic        owner;
    logic        lastServed;
    logic        errFlag;
    logic        winner;
    logic        reqAny;
    logic        lastByte;
    logic        timeoutHit;

`ifdef SD_ARB_TIMEOUT_EN
    logic [15:0] waitTimer;

    // WAIT-phase cycle counter, cleared whenever the FSM is elsewhere.
    always_ff @(posedge DataClock) begin
        if (Reset) begin
            waitTimer <= 16'd0;
        end else if (state == ST_WAIT) begin
            waitTimer <= waitTimer + 16'd1;
        end else begin
            waitTimer <= 16'd0;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        stateNext  = state;
        reqAny     = VideoReq | AudioReq;
        winner     = pickRequester(VideoReq, AudioReq, lastServed);
        lastByte   = (byteCount == 10'(SECTOR_BYTES - 1));
        timeoutHit = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        timeoutHit = (waitTimer == 16'(TIMEOUT_CYCLES - 1));
`endif
        case (state)
            ST_IDLE: begin
                if (reqAny) stateNext = ST_ISSUE;
                else        stateNext = ST_IDLE;
            end
            ST_ISSUE: stateNext = ST_WAIT;
            ST_WAIT: begin
                if (EnableDataRead)  stateNext = ST_STREAM;
                else if (timeoutHit) stateNext = ST_DONE;
                else                 stateNext = ST_WAIT;
            end
            ST_STREAM: begin
                // A dropped EnableDataRead before the last byte ends a short sector.
                if (EnableDataRead && !lastByte) stateNext = ST_STREAM;
                else                             stateNext = ST_DONE;
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge DataClock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    // Grant, address, byte routing and end-of-transfer registers.
    always_ff @(posedge DataClock) begin
        if (Reset) begin
            VideoGrant     <= 1'b0;
            AudioGrant     <= 1'b0;
            OutByte        <= 8'h00;
            VideoByteValid <= 1'b0;
            AudioByteValid <= 1'b0;
            VideoDone      <= 1'b0;
            AudioDone      <= 1'b0;
            XferErr        <= 1'b0;
            SectorAddress  <= {ADDR_W{1'b0}};
            SectorStart    <= 1'b0;
            byteCount      <= 10'd0;
            owner          <= REQ_VIDEO;
            lastServed     <= REQ_VIDEO;
            errFlag        <= 1'b0;
        end else begin
            SectorStart    <= 1'b0;
            VideoByteValid <= 1'b0;
            AudioByteValid <= 1'b0;
            VideoDone      <= 1'b0;
            AudioDone      <= 1'b0;
            XferErr        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (reqAny) begin
                        owner         <= winner;
                        VideoGrant    <= (winner == REQ_VIDEO);
                        AudioGrant    <= (winner == REQ_AUDIO);
                        SectorAddress <= (winner == REQ_AUDIO) ? AudioAddr : VideoAddr;
                        byteCount     <= 10'd0;
                        errFlag       <= 1'b0;
                    end
                end
                ST_ISSUE: SectorStart <= 1'b1;
                ST_WAIT: begin
                    if (EnableDataRead) begin
                        OutByte        <= InputData;
                        VideoByteValid <= (owner == REQ_VIDEO);
                        AudioByteValid <= (owner == REQ_AUDIO);
                        byteCount      <= 10'd1;
                    end else if (timeoutHit) begin
                        errFlag <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (EnableDataRead) begin
                        OutByte        <= InputData;
                        VideoByteValid <= (owner == REQ_VIDEO);
                        AudioByteValid <= (owner == REQ_AUDIO);
                        byteCount      <= byteCount + 10'd1;
                    end else begin
                        errFlag <= 1'b1;
                    end
                end
                ST_DONE: begin
                    VideoDone  <= (owner == REQ_VIDEO);
                    AudioDone  <= (owner == REQ_AUDIO);
                    XferErr    <= errFlag;
                    VideoGrant <= 1'b0;
                    AudioGrant <= 1'b0;
                    lastServed <= owner;
                end
                default: begin
                    VideoGrant <= 1'b0;
                    AudioGrant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: stimulus pushes expected start/byte/done
// events, a negedge monitor pops and compares whatever the DUT presents.
module tb_sd_sector_arbiter;
    import sd_audvid_pkg::*;

    localparam int ADDR_W = 16;
    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_BYTE  = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        who;
        logic [15:0] data;
        logic        err;
    } ev_t;

    logic              DataClock = 1'b0;
    logic              Reset = 1'b1;
    logic              VideoReq = 1'b0;
    logic [ADDR_W-1:0] VideoAddr = 16'h0000;
    logic              AudioReq = 1'b0;
    logic [ADDR_W-1:0] AudioAddr = 16'h0000;
    logic              VideoGrant, AudioGrant;
    logic [7:0]        OutByte;
    logic              VideoByteValid, AudioByteValid;
    logic              VideoDone, AudioDone, XferErr;
    logic [ADDR_W-1:0] SectorAddress;
    logic              SectorStart;
    logic              EnableDataRead = 1'b0;
    logic [7:0]        InputData = 8'h00;

    ev_t expQ[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  doneSeen = 0;
    int  doneExp = 0;

    always #5 DataClock = ~DataClock;

    sd_sector_arbiter #(
        .ADDR_W(ADDR_W)
`ifdef SD_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .DataClock(DataClock), .Reset(Reset),
        .VideoReq(VideoReq), .VideoAddr(VideoAddr),
        .AudioReq(AudioReq), .AudioAddr(AudioAddr),
        .VideoGrant(VideoGrant), .AudioGrant(AudioGrant),
        .OutByte(OutByte), .VideoByteValid(VideoByteValid), .AudioByteValid(AudioByteValid),
        .VideoDone(VideoDone), .AudioDone(AudioDone), .XferErr(XferErr),
        .SectorAddress(SectorAddress), .SectorStart(SectorStart),
        .EnableDataRead(EnableDataRead), .InputData(InputData)
    );

    function automatic ev_t mkEv(input logic [1:0] k, input logic w,
                                 input logic [15:0] d, input logic e);
        ev_t r;
        r.kind = k; r.who = w; r.data = d; r.err = e;
        return r;
    endfunction

    task automatic expectEv(input logic [1:0] k, input logic w,
                            input logic [15:0] d, input logic e);
        expQ.push_back(mkEv(k, w, d, e));
    endtask

    task automatic checkEv(input ev_t obs, input string name);
        ev_t exp;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got kind=%0d who=%0d data=%h err=%0d, required no event (nothing expected)",
                     name, obs.kind, obs.who, obs.data, obs.err);
        end else begin
            exp = expQ.pop_front();
            if (obs !== exp)  begin
                miscompares++;
                $display("FAIL %s: got kind=%0d who=%0d data=%h err=%0d, required kind=%0d who=%0d data=%h err=%0d",
                         name, obs.kind, obs.who, obs.data, obs.err, exp.kind, exp.who, exp.data, exp.err);
            end
        end
    endtask

    task automatic checkZero(input string name);
        logic [31:0] outs;
        outs = {VideoGrant, AudioGrant, OutByte, VideoByteValid, AudioByteValid,
                VideoDone, AudioDone, XferErr, SectorAddress, SectorStart};
        vectors++;
        if (outs !== 32'h0) begin
            miscompares++;
            $display("FAIL %s: outputs=%h required 00000000", name, outs);
        end
    endtask

    // Monitor: protocol sanity every cycle plus scoreboard pops on each event.
    always @(negedge DataClock) begin
        if (!Reset) begin
            vectors++;
            if ((VideoGrant && AudioGrant) || (VideoByteValid && AudioByteValid) ||
                (XferErr && !(VideoDone || AudioDone)) ||
                ((VideoDone || AudioDone) && (VideoGrant || AudioGrant)) ||
                (SectorStart && !(VideoGrant ^ AudioGrant))) begin
                miscompares++;
                $display("FAIL exclusivity: grants=%b%b valids=%b%b dones=%b%b err=%b start=%b",
                         VideoGrant, AudioGrant, VideoByteValid, AudioByteValid,
                         VideoDone, AudioDone, XferErr, SectorStart);
            end
            if (SectorStart)
                checkEv(mkEv(K_START, AudioGrant, SectorAddress, 1'b0), "start");
            if (VideoByteValid || AudioByteValid)
                checkEv(mkEv(K_BYTE, AudioByteValid, {8'h00, OutByte}, 1'b0), "byte");
            if (VideoDone || AudioDone) begin
                doneSeen++;
                checkEv(mkEv(K_DONE, AudioDone, 16'h0000, XferErr), "done");
            end
        end
    end

    // Reader model: waits for SectorStart, then streams total bytes seed+i.
    task automatic readerRun(input int total, input int pushN, input logic who,
                             input logic [7:0] seed, input bit pushDone);
        int guard = 0;
        while (SectorStart !== 1'b1 && guard < 100) begin
            @(posedge DataClock); #1;
            guard++;
        end
        vectors++;
        if (guard >= 100) begin
            miscompares++;
            $display("FAIL reader_start: SectorStart=0 after 100 cycles, required 1");
        end
        for (int i = 0; i < total; i++) begin
            EnableDataRead = 1'b1;
            InputData = 8'(i) + seed;
            if (i < pushN) expectEv(K_BYTE, who, {8'h00, 8'(i) + seed}, 1'b0);
            if (pushDone && i == pushN - 1) expectEv(K_DONE, who, 16'h0000, pushN < SECTOR_BYTES);
            @(posedge DataClock); #1;
        end
        EnableDataRead = 1'b0;
    endtask

    task automatic waitDone(input int target, input bit dropV, input bit dropA);
        int guard = 0;
        @(negedge DataClock); #1;
        while (doneSeen < target && guard < 64) begin
            @(negedge DataClock); #1;
            guard++;
        end
        vectors++;
        if (guard >= 64) begin
            miscompares++;
            $display("FAIL done_wait: dones seen=%0d required %0d", doneSeen, target);
        end
        if (dropV) VideoReq = 1'b0;
        if (dropA) AudioReq = 1'b0;
        @(posedge DataClock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge DataClock);
        #1;
        checkZero("reset_state");
        Reset = 1'b0;

        // Tie from reset: audio, video, audio.
        VideoAddr = 16'h0A00; AudioAddr = 16'h0B00;
        VideoReq = 1'b1; AudioReq = 1'b1;
        expectEv(K_START, REQ_AUDIO, 16'h0B00, 1'b0);
        readerRun(8, 8, REQ_AUDIO, 8'h10, 1'b1);
        doneExp++; waitDone(doneExp, 1'b0, 1'b0);
        expectEv(K_START, REQ_VIDEO, 16'h0A00, 1'b0);
        readerRun(8, 8, REQ_VIDEO, 8'h20, 1'b1);
        doneExp++; waitDone(doneExp, 1'b0, 1'b0);
        expectEv(K_START, REQ_AUDIO, 16'h0B00, 1'b0);
        readerRun(8, 8, REQ_AUDIO, 8'h30, 1'b1);
        doneExp++; waitDone(doneExp, 1'b1, 1'b1);

        // Full 512-byte video sector, data 00..FF repeating.
        VideoAddr = 16'h0123; VideoReq = 1'b1;
        expectEv(K_START, REQ_VIDEO, 16'h0123, 1'b0);
        readerRun(512, 512, REQ_VIDEO, 8'h00, 1'b1);
        doneExp++; waitDone(doneExp, 1'b1, 1'b0);

        // Short audio sector: 100 bytes then Done with XferErr.
        AudioAddr = 16'h4567; AudioReq = 1'b1;
        expectEv(K_START, REQ_AUDIO, 16'h4567, 1'b0);
        readerRun(100, 100, REQ_AUDIO, 8'h55, 1'b1);
        doneExp++; waitDone(doneExp, 1'b0, 1'b1);

        // Reader overruns to 520 bytes; Req dropped right after grant.
        AudioAddr = 16'hBEEF; AudioReq = 1'b1;
        expectEv(K_START, REQ_AUDIO, 16'hBEEF, 1'b0);
        @(posedge DataClock); #1;
        AudioReq = 1'b0;
        readerRun(520, 512, REQ_AUDIO, 8'h80, 1'b1);
        doneExp++; waitDone(doneExp, 1'b0, 1'b0);

        // Reset at byte 200 of a video sector; last-served must return to video.
        VideoAddr = 16'h7777; VideoReq = 1'b1;
        expectEv(K_START, REQ_VIDEO, 16'h7777, 1'b0);
        readerRun(200, 200, REQ_VIDEO, 8'h00, 1'b0);
        Reset = 1'b1; VideoReq = 1'b0;
        expQ.delete();
        @(posedge DataClock); #1;
        checkZero("reset_mid_stream");
        Reset = 1'b0;
        VideoAddr = 16'h1111; AudioAddr = 16'h2222;
        VideoReq = 1'b1; AudioReq = 1'b1;
        expectEv(K_START, REQ_AUDIO, 16'h2222, 1'b0);
        readerRun(8, 8, REQ_AUDIO, 8'h40, 1'b1);
        doneExp++; waitDone(doneExp, 1'b1, 1'b1);

`ifdef SD_ARB_TIMEOUT_EN
        // No data: WAIT lasts 16 edges, Done visible on the 17th edge after SectorStart's.
        begin
            int n = 0;
            VideoAddr = 16'h3333; VideoReq = 1'b1;
            expectEv(K_START, REQ_VIDEO, 16'h3333, 1'b0);
            expectEv(K_DONE, REQ_VIDEO, 16'h0000, 1'b1);
            while (SectorStart !== 1'b1 && n < 100) begin
                @(posedge DataClock); #1; n++;
            end
            n = 0;
            while (VideoDone !== 1'b1 && n < 100) begin
                @(posedge DataClock); #1; n++;
            end
            vectors++;
            if (n != 17) begin
                miscompares++;
                $display("FAIL timeout_latency: %0d cycles, required 17", n);
            end
            doneExp++; waitDone(doneExp, 1'b1, 1'b0);
        end
`endif

        repeat (4) @(posedge DataClock);
        #1;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d expected events outstanding, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
